cpu86_mem_arbiter: RTL and testbench
====================================

# cpu86_mem_arbiter

Two-requester arbiter for the cpu86 memory port. It merges an instruction-fetch request stream (port 0) and an execution-unit data stream (port 1) onto the single 64-bit memory request channel. It tracks outstanding reads in a small in-order ID FIFO and returns each 32-bit memory response to the requester that issued it. It sits between the cpu86 core internals and the memory model/controller, which answers reads in order and never back-pressures responses.

## Interface

Parameters:
- MAX_OUTSTANDING, 4: maximum reads in flight (issued, response not yet received); power of two, 2..16.
- WE_BIT, 63: bit of the request tdata that marks a write (1 = write, no response; 0 = read, exactly one response).

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- s_axis_req0_tvalid / s_axis_req0_tready / s_axis_req0_tdata  in/out/in  1/1/64  requester 0 (fetch) request
- s_axis_req1_tvalid / s_axis_req1_tready / s_axis_req1_tdata  in/out/in  1/1/64  requester 1 (data) request
- m_axis_res0_tvalid / m_axis_res0_tdata  out  1/32  read response to requester 0; no tready
- m_axis_res1_tvalid / m_axis_res1_tdata  out  1/32  read response to requester 1; no tready
- m_axis_req_tvalid / m_axis_req_tready / m_axis_req_tdata  out/in/out  1/1/64  merged request to memory
- s_axis_res_tvalid / s_axis_res_tdata  in  1/32  memory response; no tready, always accepted
- err_unexpected_res  out  1  sticky flag: a response arrived with no read outstanding

## Operation

- Output stage: one register slot (m_axis_req_tvalid/tdata). The slot is free when m_axis_req_tvalid=0 or m_axis_req_tready=1.
- A requester is eligible when its tvalid=1 and either its tdata[WE_BIT]=1, or the ID FIFO is not full (count < MAX_OUTSTANDING).
- Grant happens only when the slot is free:
  - Exactly one eligible requester: that requester is granted.
  - Both eligible: the requester not granted last time wins (round-robin). last_grant updates only on an actual grant.
- s_axis_reqX_tready = grant X (combinational from valids, tdata[WE_BIT], count, slot state, last_grant). At most one tready is high per cycle.
- On grant, the requester's tdata loads into the slot unmodified. If the request is a read, the requester ID (0/1) is pushed into the ID FIFO in the same cycle.
- On s_axis_res_tvalid=1:
  - The FIFO head is popped and the data is routed to m_axis_res{head}.
  - If the FIFO is empty, the response is dropped and err_unexpected_res is set. It clears only on reset.
- Push and pop in the same cycle: count is unchanged and the FIFO pointers wrap modulo MAX_OUTSTANDING.
- A write may be granted while the FIFO is full. A blocked read on one port does not block the other port.
- Reset mid-operation: all state clears. In-flight responses arriving after reset are treated as unexpected.

## Timing

Reset values:
- m_axis_req_tvalid=0, m_axis_req_tdata=0
- m_axis_res0/1_tvalid=0, m_axis_res0/1_tdata=0
- err_unexpected_res=0
- FIFO count=0, pointers=0
- last_grant=1, so port 0 wins the first tie

Latency and handshake rules:
- Request latency: a request accepted in cycle N appears on m_axis_req in cycle N+1.
- Throughput: one request per cycle while m_axis_req_tready=1.
- m_axis_req_tvalid/tdata hold stable while tvalid=1 and tready=0. No combinational path from s_axis_reqX_tdata to m_axis_req_tdata.
- Response latency: a response presented in cycle N appears on m_axis_resX in cycle N+1, registered, one-cycle pulse. The other response port's tvalid is 0 that cycle.
- FIFO occupancy seen by the eligibility check is the registered count. A pop in the same cycle does not free a slot for a read until the next cycle.

## Test plan

- Reset, then both ports present reads A0/B0 simultaneously with m_axis_req_tready=1 → port 0 granted at cycle 1, port 1 at cycle 2; memory sees A0 then B0 on consecutive cycles.
- Memory returns 0x11111111 then 0x22222222 for those reads → m_axis_res0 pulses 0x11111111 one cycle after the first, m_axis_res1 pulses 0x22222222 one cycle after the second.
- Port 0 issues 4 reads with no responses (MAX_OUTSTANDING=4); port 0 then holds a 5th read while port 1 presents a write (bit63=1) → port 0 tready stays 0, the write is accepted; after one response, port 0's read is accepted the following cycle.
- Hold m_axis_req_tready=0 for 5 cycles with both ports valid → the slot holds its first request unchanged, both treadys stay 0; on release, requests alternate 0,1,0,1.
- Pulse s_axis_res_tvalid with no reads outstanding → no m_axis_resX pulse, err_unexpected_res=1 and stays 1 until resetn falls.
- Assert resetn=0 asynchronously with 3 reads outstanding → all outputs return to reset values immediately; a later response sets err_unexpected_res.

Source files
------------

// File: rtl/cpu86_mem_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cpu86_mem_arbiter_if : request/response bus bundle for the memory arbiter|
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
interface cpu86_mem_arbiter_if;
   logic        s_axis_req0_tvalid;
   logic        s_axis_req0_tready;
   logic [63:0] s_axis_req0_tdata;
   logic        s_axis_req1_tvalid;
   logic        s_axis_req1_tready;
   logic [63:0] s_axis_req1_tdata;
   logic        m_axis_res0_tvalid;
   logic [31:0] m_axis_res0_tdata;
   logic        m_axis_res1_tvalid;
   logic [31:0] m_axis_res1_tdata;
   logic        m_axis_req_tvalid;
   logic        m_axis_req_tready;
   logic [63:0] m_axis_req_tdata;
   logic        s_axis_res_tvalid;
   logic [31:0] s_axis_res_tdata;
   logic        err_unexpected_res;

   // Arbiter side
   modport slave (
      input  s_axis_req0_tvalid, s_axis_req0_tdata,
      output s_axis_req0_tready,
      input  s_axis_req1_tvalid, s_axis_req1_tdata,
      output s_axis_req1_tready,
      output m_axis_res0_tvalid, m_axis_res0_tdata,
      output m_axis_res1_tvalid, m_axis_res1_tdata,
      output m_axis_req_tvalid, m_axis_req_tdata,
      input  m_axis_req_tready,
      input  s_axis_res_tvalid, s_axis_res_tdata,
      output err_unexpected_res
   );

   // Core / memory side
   modport master (
      output s_axis_req0_tvalid, s_axis_req0_tdata,
      input  s_axis_req0_tready,
      output s_axis_req1_tvalid, s_axis_req1_tdata,
      input  s_axis_req1_tready,
      input  m_axis_res0_tvalid, m_axis_res0_tdata,
      input  m_axis_res1_tvalid, m_axis_res1_tdata,
      input  m_axis_req_tvalid, m_axis_req_tdata,
      output m_axis_req_tready,
      output s_axis_res_tvalid, s_axis_res_tdata,
      input  err_unexpected_res
   );
endinterface
`default_nettype wire

// File: rtl/cpu86_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cpu86_mem_arbiter : round-robin merge of fetch/data requests with        |
// | in-order read-ID tracking for response routing. Revision 1.0             |
// +--------------------------------------------------------------------------+
module cpu86_mem_arbiter #(
   parameter int MAX_OUTSTANDING = 4,
   parameter int WE_BIT          = 63
) (
   input  logic                       clk,
   input  logic                       resetn,
   cpu86_mem_arbiter_if.slave         bus
);

   localparam int c_ptr_w = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int c_cnt_w = c_ptr_w + 1;
   localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(MAX_OUTSTANDING);

   logic                       r_req_tvalid;
   logic [63:0]                r_req_tdata;
   logic                       r_res0_tvalid;
   logic [31:0]                r_res0_tdata;
   logic                       r_res1_tvalid;
   logic [31:0]                r_res1_tdata;
   logic                       r_err;
   logic                       r_last_grant;
   logic [MAX_OUTSTANDING-1:0] r_id_fifo;
   logic [c_ptr_w-1:0]         r_wr_ptr;
   logic [c_ptr_w-1:0]         r_rd_ptr;
   logic [c_cnt_w-1:0]         r_count;

   logic                       w_slot_free;
   logic                       w_fifo_full;
   logic                       w_fifo_empty;
   logic                       w_elig0;
   logic                       w_elig1;
   logic                       w_grant0;
   logic                       w_grant1;
   logic                       w_grant_any;
   logic [63:0]                w_grant_data;
   logic                       w_push;
   logic                       w_pop;
   logic                       w_head_id;

   assign w_slot_free  = !r_req_tvalid || bus.m_axis_req_tready;
   assign w_fifo_full  = (r_count == c_full);
   assign w_fifo_empty = (r_count == '0);

   // Writes never need an ID slot, so only reads are held off by a full FIFO
   assign w_elig0 = bus.s_axis_req0_tvalid && (bus.s_axis_req0_tdata[WE_BIT] || !w_fifo_full);
   assign w_elig1 = bus.s_axis_req1_tvalid && (bus.s_axis_req1_tdata[WE_BIT] || !w_fifo_full);

   assign w_grant0    = w_slot_free && w_elig0 && (!w_elig1 || r_last_grant);
   assign w_grant1    = w_slot_free && w_elig1 && (!w_elig0 || !r_last_grant);
   assign w_grant_any = w_grant0 || w_grant1;

   assign w_grant_data = w_grant1 ? bus.s_axis_req1_tdata : bus.s_axis_req0_tdata;
   assign w_push       = w_grant_any && !w_grant_data[WE_BIT];
   assign w_pop        = bus.s_axis_res_tvalid && !w_fifo_empty;
   assign w_head_id    = r_id_fifo[r_rd_ptr];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_req_tvalid  <= 1'b0;
         r_req_tdata   <= '0;
         r_res0_tvalid <= 1'b0;
         r_res0_tdata  <= '0;
         r_res1_tvalid <= 1'b0;
         r_res1_tdata  <= '0;
         r_err         <= 1'b0;
         r_last_grant  <= 1'b1;
         r_id_fifo     <= '0;
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_count       <= '0;
      end else begin
         if (w_grant_any) begin
            r_req_tvalid <= 1'b1;
            r_req_tdata  <= w_grant_data;
            r_last_grant <= w_grant1;
         end else if (bus.m_axis_req_tready) begin
            r_req_tvalid <= 1'b0;
         end

         if (w_push) begin
            r_id_fifo[r_wr_ptr] <= w_grant1;
            r_wr_ptr            <= r_wr_ptr + c_ptr_w'(1);
         end

         r_res0_tvalid <= w_pop && !w_head_id;
         r_res1_tvalid <= w_pop && w_head_id;
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            if (w_head_id)
               r_res1_tdata <= bus.s_axis_res_tdata;
            else
               r_res0_tdata <= bus.s_axis_res_tdata;
         end

         if (bus.s_axis_res_tvalid && w_fifo_empty)
            r_err <= 1'b1;

         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_cnt_w'(1);
            2'b01:   r_count <= r_count - c_cnt_w'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign bus.s_axis_req0_tready = w_grant0;
   assign bus.s_axis_req1_tready = w_grant1;
   assign bus.m_axis_req_tvalid  = r_req_tvalid;
   assign bus.m_axis_req_tdata   = r_req_tdata;
   assign bus.m_axis_res0_tvalid = r_res0_tvalid;
   assign bus.m_axis_res0_tdata  = r_res0_tdata;
   assign bus.m_axis_res1_tvalid = r_res1_tvalid;
   assign bus.m_axis_res1_tdata  = r_res1_tdata;
   assign bus.err_unexpected_res = r_err;

endmodule
`default_nettype wire

// File: tb/tb_cpu86_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cpu86_mem_arbiter : directed vector bench for cpu86_mem_arbiter       |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_cpu86_mem_arbiter;

   logic clk = 1'b0;
   logic resetn;
   always #5 clk = ~clk;

   cpu86_mem_arbiter_if bus();

   cpu86_mem_arbiter #(.MAX_OUTSTANDING(4), .WE_BIT(63)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   typedef struct {
      logic        v0;  logic [63:0] d0;
      logic        v1;  logic [63:0] d1;
      logic        mrdy;
      logic        rv;  logic [31:0] rd;
      logic        rdy0; logic rdy1;
      logic        mv;  logic [63:0] md;
      logic        r0v; logic [31:0] r0d;
      logic        r1v; logic [31:0] r1d;
      logic        err;
   } vec_t;

   localparam logic [63:0] c_a0 = 64'h0000_0000_0000_A000;
   localparam logic [63:0] c_b0 = 64'h0000_0000_0000_B000;
   localparam logic [63:0] c_w0 = 64'h8000_0000_0000_0C00;
   localparam logic [63:0] c_w1 = 64'h8000_0000_0000_0D01;
   localparam logic [63:0] c_w2 = 64'h8000_0000_0000_0E02;
   localparam logic [63:0] c_wf = 64'h8000_0000_0000_0F0F;

   int   n_checks = 0;
   int   n_fail   = 0;
   vec_t tbl [12];
   logic [63:0] rd_addr [5];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v0, input logic [63:0] d0, input logic v1,
                        input logic [63:0] d1, input logic mrdy, input logic rv,
                        input logic [31:0] rd);
      @(negedge clk);
      bus.s_axis_req0_tvalid = v0;
      bus.s_axis_req0_tdata  = d0;
      bus.s_axis_req1_tvalid = v1;
      bus.s_axis_req1_tdata  = d1;
      bus.m_axis_req_tready  = mrdy;
      bus.s_axis_res_tvalid  = rv;
      bus.s_axis_res_tdata   = rd;
   endtask

   task automatic check_ready(input string tag, input logic e0, input logic e1);
      #1;
      check({tag, " tready0"}, 64'(bus.s_axis_req0_tready), 64'(e0));
      check({tag, " tready1"}, 64'(bus.s_axis_req1_tready), 64'(e1));
   endtask

   task automatic check_out(input string tag, input logic mv, input logic [63:0] md,
                            input logic r0v, input logic [31:0] r0d, input logic r1v,
                            input logic [31:0] r1d, input logic err);
      @(posedge clk);
      #1;
      check({tag, " req_tvalid"}, 64'(bus.m_axis_req_tvalid), 64'(mv));
      if (mv) check({tag, " req_tdata"}, bus.m_axis_req_tdata, md);
      check({tag, " res0_tvalid"}, 64'(bus.m_axis_res0_tvalid), 64'(r0v));
      if (r0v) check({tag, " res0_tdata"}, 64'(bus.m_axis_res0_tdata), 64'(r0d));
      check({tag, " res1_tvalid"}, 64'(bus.m_axis_res1_tvalid), 64'(r1v));
      if (r1v) check({tag, " res1_tdata"}, 64'(bus.m_axis_res1_tdata), 64'(r1d));
      check({tag, " err"}, 64'(bus.err_unexpected_res), 64'(err));
   endtask

   task automatic apply_reset(input string tag);
      @(negedge clk);
      resetn = 1'b0;
      bus.s_axis_req0_tvalid = 1'b0;
      bus.s_axis_req1_tvalid = 1'b0;
      bus.s_axis_res_tvalid  = 1'b0;
      bus.m_axis_req_tready  = 1'b1;
      @(posedge clk);
      #1;
      check({tag, " rst req_tvalid"}, 64'(bus.m_axis_req_tvalid), 64'd0);
      check({tag, " rst req_tdata"}, bus.m_axis_req_tdata, 64'd0);
      check({tag, " rst res0_tvalid"}, 64'(bus.m_axis_res0_tvalid), 64'd0);
      check({tag, " rst res0_tdata"}, 64'(bus.m_axis_res0_tdata), 64'd0);
      check({tag, " rst res1_tvalid"}, 64'(bus.m_axis_res1_tvalid), 64'd0);
      check({tag, " rst res1_tdata"}, 64'(bus.m_axis_res1_tdata), 64'd0);
      check({tag, " rst err"}, 64'(bus.err_unexpected_res), 64'd0);
      @(negedge clk);
      resetn = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      resetn = 1'b0;
      bus.s_axis_req0_tvalid = 1'b0;
      bus.s_axis_req0_tdata  = '0;
      bus.s_axis_req1_tvalid = 1'b0;
      bus.s_axis_req1_tdata  = '0;
      bus.m_axis_req_tready  = 1'b0;
      bus.s_axis_res_tvalid  = 1'b0;
      bus.s_axis_res_tdata   = '0;

      //        v0 d0    v1 d1    mrdy rv rd            rdy0 rdy1 mv md   r0v r0d           r1v r1d           err
      tbl[0]  = '{0, 0,    0, 0,    1, 0, 0,            0, 0, 0, 0,    0, 0,            0, 0,            0};
      tbl[1]  = '{1, c_a0, 1, c_b0, 1, 0, 0,            1, 0, 1, c_a0, 0, 0,            0, 0,            0};
      tbl[2]  = '{0, 0,    1, c_b0, 1, 0, 0,            0, 1, 1, c_b0, 0, 0,            0, 0,            0};
      tbl[3]  = '{0, 0,    0, 0,    1, 1, 32'h11111111, 0, 0, 0, 0,    1, 32'h11111111, 0, 0,            0};
      tbl[4]  = '{0, 0,    0, 0,    1, 1, 32'h22222222, 0, 0, 0, 0,    0, 0,            1, 32'h22222222, 0};
      tbl[5]  = '{0, 0,    0, 0,    1, 0, 0,            0, 0, 0, 0,    0, 0,            0, 0,            0};
      tbl[6]  = '{1, c_w0, 1, c_w1, 1, 0, 0,            1, 0, 1, c_w0, 0, 0,            0, 0,            0};
      tbl[7]  = '{1, c_w2, 1, c_w1, 1, 0, 0,            0, 1, 1, c_w1, 0, 0,            0, 0,            0};
      tbl[8]  = '{1, c_w2, 0, 0,    1, 0, 0,            1, 0, 1, c_w2, 0, 0,            0, 0,            0};
      tbl[9]  = '{0, 0,    0, 0,    1, 0, 0,            0, 0, 0, 0,    0, 0,            0, 0,            0};
      tbl[10] = '{0, 0,    0, 0,    1, 1, 32'hDEADBEEF, 0, 0, 0, 0,    0, 0,            0, 0,            1};
      tbl[11] = '{0, 0,    0, 0,    1, 0, 0,            0, 0, 0, 0,    0, 0,            0, 0,            1};

      for (int i = 0; i < 5; i++) rd_addr[i] = 64'h0000_0000_0001_0000 + 64'(i);

      apply_reset("init");

      for (int i = 0; i < 12; i++) begin
         drive(tbl[i].v0, tbl[i].d0, tbl[i].v1, tbl[i].d1, tbl[i].mrdy, tbl[i].rv, tbl[i].rd);
         check_ready($sformatf("vec%0d", i), tbl[i].rdy0, tbl[i].rdy1);
         check_out($sformatf("vec%0d", i), tbl[i].mv, tbl[i].md, tbl[i].r0v, tbl[i].r0d,
                   tbl[i].r1v, tbl[i].r1d, tbl[i].err);
      end

      // Full ID FIFO: reads on port 0 stall, a write on port 1 still passes
      apply_reset("full");
      for (int i = 0; i < 4; i++) begin
         drive(1, rd_addr[i], 0, 0, 1, 0, 0);
         check_ready($sformatf("fill%0d", i), 1, 0);
         check_out($sformatf("fill%0d", i), 1, rd_addr[i], 0, 0, 0, 0, 0);
      end
      drive(1, rd_addr[4], 1, c_wf, 1, 0, 0);
      check_ready("full_wr", 0, 1);
      check_out("full_wr", 1, c_wf, 0, 0, 0, 0, 0);
      drive(1, rd_addr[4], 0, 0, 1, 0, 0);
      check_ready("full_hold", 0, 0);
      check_out("full_hold", 0, 0, 0, 0, 0, 0, 0);
      drive(1, rd_addr[4], 0, 0, 1, 1, 32'hA5A5_0001);
      check_ready("full_pop", 0, 0);
      check_out("full_pop", 0, 0, 1, 32'hA5A5_0001, 0, 0, 0);
      drive(1, rd_addr[4], 0, 0, 1, 0, 0);
      check_ready("full_after", 1, 0);
      check_out("full_after", 1, rd_addr[4], 0, 0, 0, 0, 0);

      // Back-pressure: slot holds, then strict alternation on release
      apply_reset("bp");
      drive(1, c_a0, 1, c_b0, 0, 0, 0);
      check_ready("bp_first", 1, 0);
      check_out("bp_first", 1, c_a0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         drive(1, c_a0 + 64'd1, 1, c_b0, 0, 0, 0);
         check_ready($sformatf("bp_hold%0d", i), 0, 0);
         check_out($sformatf("bp_hold%0d", i), 1, c_a0, 0, 0, 0, 0, 0);
      end
      drive(1, c_a0 + 64'd1, 1, c_b0, 1, 0, 0);
      check_ready("bp_rel1", 0, 1);
      check_out("bp_rel1", 1, c_b0, 0, 0, 0, 0, 0);
      drive(1, c_a0 + 64'd1, 1, c_b0 + 64'd1, 1, 0, 0);
      check_ready("bp_rel0", 1, 0);
      check_out("bp_rel0", 1, c_a0 + 64'd1, 0, 0, 0, 0, 0);
      drive(0, 0, 1, c_b0 + 64'd1, 1, 0, 0);
      check_ready("bp_rel1b", 0, 1);
      check_out("bp_rel1b", 1, c_b0 + 64'd1, 0, 0, 0, 0, 0);

      // Asynchronous reset with three reads outstanding
      apply_reset("ar");
      drive(1, rd_addr[0], 1, rd_addr[1], 1, 0, 0);
      check_ready("ar_g0", 1, 0);
      check_out("ar_g0", 1, rd_addr[0], 0, 0, 0, 0, 0);
      drive(0, 0, 1, rd_addr[1], 1, 0, 0);
      check_ready("ar_g1", 0, 1);
      check_out("ar_g1", 1, rd_addr[1], 0, 0, 0, 0, 0);
      drive(1, rd_addr[2], 0, 0, 1, 0, 0);
      check_ready("ar_g2", 1, 0);
      check_out("ar_g2", 1, rd_addr[2], 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0);
      check_ready("ar_stall", 0, 0);
      check_out("ar_stall", 1, rd_addr[2], 0, 0, 0, 0, 0);
      @(negedge clk);
      #2;
      resetn = 1'b0;
      #1;
      check("ar_async req_tvalid", 64'(bus.m_axis_req_tvalid), 64'd0);
      check("ar_async req_tdata", bus.m_axis_req_tdata, 64'd0);
      check("ar_async err", 64'(bus.err_unexpected_res), 64'd0);
      @(negedge clk);
      resetn = 1'b1;
      drive(0, 0, 0, 0, 1, 1, 32'h33333333);
      check_ready("ar_late", 0, 0);
      check_out("ar_late", 0, 0, 0, 0, 0, 0, 1);
      drive(0, 0, 0, 0, 1, 0, 0);
      check_out("ar_sticky", 0, 0, 0, 0, 0, 0, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
